// File: rtl/preset_set_ctrl.sv
// Preset time setter: edits a BCD mm:ss preset digit by digit and strobes the
// committed value into the countdown datapath when the set switch is released.
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en              set switch level; high requests edit mode
//   pb_sel/inc/clr      one-cycle button pulses: move cursor / bump digit / zero all
//   preset_min/sec      BCD {tens,units}; working digits in EDIT, committed otherwise
//   cursor              3=min tens, 2=min units, 1=sec tens, 0=sec units
//   blink_on            cursor digit display phase (1=visible)
//   editing             high in EDIT
//   load_pulse          one-cycle strobe in the COMMIT cycle
//   preset_zero         committed preset is 00:00 (combinational)
module preset_set_ctrl #(
  parameter int unsigned BLINK_HALF = 25000000,
  parameter logic [7:0]  INIT_MIN   = 8'h01,
  parameter logic [7:0]  INIT_SEC   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic       pb_sel,
  input  logic       pb_inc,
  input  logic       pb_clr,
  output logic [7:0] preset_min,
  output logic [7:0] preset_sec,
  output logic [1:0] cursor,
  output logic       blink_on,
  output logic       editing,
  output logic       load_pulse,
  output logic       preset_zero
);

  localparam int unsigned       CNT_W    = $clog2(BLINK_HALF);
  localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(BLINK_HALF - 1);
  localparam logic [15:0]       INIT_VAL = {INIT_MIN, INIT_SEC};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EDIT   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      work_q, work_d;   // {mt, mu, st, su}
  logic [15:0]      comm_q, comm_d;
  logic [1:0]       cursor_q, cursor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  logic             enter;
  logic             edit_act;
  logic             accept;
  logic [3:0]       cur_digit;
  logic [3:0]       digit_max;
  logic [3:0]       digit_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (set_en)  state_d = S_EDIT;
      S_EDIT:   if (!set_en) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Buttons only count in EDIT while the switch is still held; the release
  // cycle itself ignores them.
  assign enter    = (state_q == S_IDLE) && set_en;
  assign edit_act = (state_q == S_EDIT) && set_en;
  assign accept   = edit_act && (pb_sel || pb_inc || pb_clr);

  // Digit increment with per-digit wrap (seconds tens wraps at 5)
  always_comb begin
    cur_digit = work_q[{cursor_q, 2'b00} +: 4];
    digit_max = (cursor_q == 2'd1) ? 4'd5 : 4'd9;
    digit_inc = (cur_digit >= digit_max) ? 4'd0 : cur_digit + 4'd1;
  end

  // Working digits, cursor and committed digits next values
  always_comb begin
    work_d   = work_q;
    cursor_d = cursor_q;
    comm_d   = comm_q;
    if (enter) begin
      work_d   = comm_q;
      cursor_d = 2'd3;
    end else if (edit_act) begin
      if (pb_clr)      work_d = 16'h0000;
      else if (pb_inc) work_d[{cursor_q, 2'b00} +: 4] = digit_inc;
      if (pb_sel)      cursor_d = cursor_q - 2'd1;
    end
    // Commit on the edge into COMMIT so the new value is visible during it
    if ((state_q == S_EDIT) && !set_en) comm_d = work_q;
  end

  // Blink counter: free-runs in EDIT, restarts visible on any accepted button
  always_comb begin
    cnt_d   = '0;
    blink_d = 1'b1;
    if (edit_act && !accept) begin
      if (cnt_q == CNT_TERM) begin
        blink_d = ~blink_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        blink_d = blink_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= INIT_VAL;
      comm_q   <= INIT_VAL;
      cursor_q <= 2'd3;
      cnt_q    <= '0;
      blink_q  <= 1'b1;
    end else begin
      work_q   <= work_d;
      comm_q   <= comm_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
    end
  end

  // Outputs decoded from registered state and registers
  always_comb begin
    editing     = (state_q == S_EDIT);
    load_pulse  = (state_q == S_COMMIT);
    cursor      = cursor_q;
    blink_on    = blink_q;
    preset_min  = editing ? work_q[15:8] : comm_q[15:8];
    preset_sec  = editing ? work_q[7:0]  : comm_q[7:0];
    preset_zero = (comm_q == 16'h0000);
  end

endmodule

// File: tb/tb_preset_set_ctrl.sv
// Directed bench for preset_set_ctrl with a short blink half-period.
module tb_preset_set_ctrl;

  logic       clk;
  logic       rst_n;
  logic       set_en;
  logic       pb_sel;
  logic       pb_inc;
  logic       pb_clr;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [1:0] cursor;
  logic       blink_on;
  logic       editing;
  logic       load_pulse;
  logic       preset_zero;

  int n_cmp;
  int n_bad;

  preset_set_ctrl #(
    .BLINK_HALF(4),
    .INIT_MIN  (8'h01),
    .INIT_SEC  (8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (set_en),
    .pb_sel     (pb_sel),
    .pb_inc     (pb_inc),
    .pb_clr     (pb_clr),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .cursor     (cursor),
    .blink_on   (blink_on),
    .editing    (editing),
    .load_pulse (load_pulse),
    .preset_zero(preset_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic inc, input logic c);
    pb_sel = s; pb_inc = inc; pb_clr = c;
    step(1);
    pb_sel = 1'b0; pb_inc = 1'b0; pb_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_en = 1'b0; pb_sel = 1'b0; pb_inc = 1'b0; pb_clr = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    n_cmp++; if (preset_min !== 8'h01) begin n_bad++; $display("FAIL reset_min got %h want 01", preset_min); end
    n_cmp++; if (preset_sec !== 8'h00) begin n_bad++; $display("FAIL reset_sec got %h want 00", preset_sec); end
    n_cmp++; if (editing !== 1'b0) begin n_bad++; $display("FAIL reset_editing got %b want 0", editing); end
    n_cmp++; if (load_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_load got %b want 0", load_pulse); end
    n_cmp++; if (preset_zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", preset_zero); end
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL reset_blink got %b want 1", blink_on); end
    n_cmp++; if (cursor !== 2'd3) begin n_bad++; $display("FAIL reset_cursor got %0d want 3", cursor); end
  endtask

  task automatic test_units_wrap();
    set_en = 1'b1;
    step(1);
    n_cmp++; if (editing !== 1'b1) begin n_bad++; $display("FAIL wrap_enter got %b want 1", editing); end
    n_cmp++; if (cursor !== 2'd3) begin n_bad++; $display("FAIL wrap_cursor3 got %0d want 3", cursor); end
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (cursor !== 2'd0) begin n_bad++; $display("FAIL wrap_cursor0 got %0d want 0", cursor); end
    for (int i = 0; i < 12; i++) pulse(1'b0, 1'b1, 1'b0);
    n_cmp++; if (preset_sec !== 8'h02) begin n_bad++; $display("FAIL wrap_work_sec got %h want 02", preset_sec); end
    set_en = 1'b0;
    step(1);
    n_cmp++; if (load_pulse !== 1'b1) begin n_bad++; $display("FAIL wrap_load got %b want 1", load_pulse); end
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0102) begin n_bad++; $display("FAIL wrap_commit got %h want 0102", {preset_min, preset_sec}); end
    n_cmp++; if (editing !== 1'b0) begin n_bad++; $display("FAIL wrap_commit_editing got %b want 0", editing); end
    step(1);
    n_cmp++; if (load_pulse !== 1'b0) begin n_bad++; $display("FAIL wrap_load_once got %b want 0", load_pulse); end
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0102) begin n_bad++; $display("FAIL wrap_idle got %h want 0102", {preset_min, preset_sec}); end
  endtask

  task automatic test_idle_pulses();
    pulse(1'b1, 1'b1, 1'b1);
    step(1);
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0102) begin n_bad++; $display("FAIL idle_pulse_val got %h want 0102", {preset_min, preset_sec}); end
    n_cmp++; if (cursor !== 2'd0) begin n_bad++; $display("FAIL idle_pulse_cursor got %0d want 0", cursor); end
    n_cmp++; if (editing !== 1'b0 || load_pulse !== 1'b0) begin n_bad++; $display("FAIL idle_pulse_ctl got %b%b want 00", editing, load_pulse); end
  endtask

  task automatic test_no_carry();
    set_en = 1'b1;
    step(1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    n_cmp++; if (cursor !== 2'd1) begin n_bad++; $display("FAIL nocarry_cursor got %0d want 1", cursor); end
    for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1, 1'b0);
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0112) begin n_bad++; $display("FAIL nocarry_work got %h want 0112", {preset_min, preset_sec}); end
    // Button pressed in the release cycle must be ignored
    set_en = 1'b0; pb_inc = 1'b1;
    step(1);
    pb_inc = 1'b0;
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0112) begin n_bad++; $display("FAIL nocarry_commit got %h want 0112", {preset_min, preset_sec}); end
    n_cmp++; if (load_pulse !== 1'b1) begin n_bad++; $display("FAIL nocarry_load got %b want 1", load_pulse); end
    step(1);
  endtask

  task automatic test_sel_inc_clr();
    set_en = 1'b1;
    step(1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    n_cmp++; if (preset_min !== 8'h02) begin n_bad++; $display("FAIL selinc_min got %h want 02", preset_min); end
    n_cmp++; if (cursor !== 2'd1) begin n_bad++; $display("FAIL selinc_cursor got %0d want 1", cursor); end
    pulse(1'b0, 1'b1, 1'b1);
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0000) begin n_bad++; $display("FAIL clr_work got %h want 0000", {preset_min, preset_sec}); end
    n_cmp++; if (cursor !== 2'd1) begin n_bad++; $display("FAIL clr_cursor got %0d want 1", cursor); end
    n_cmp++; if (preset_zero !== 1'b0) begin n_bad++; $display("FAIL clr_zero_early got %b want 0", preset_zero); end
    set_en = 1'b0;
    step(1);
    n_cmp++; if (preset_zero !== 1'b1) begin n_bad++; $display("FAIL clr_zero got %b want 1", preset_zero); end
    n_cmp++; if (load_pulse !== 1'b1) begin n_bad++; $display("FAIL clr_load got %b want 1", load_pulse); end
    step(1);
  endtask

  task automatic test_blink();
    logic exp;
    set_en = 1'b1;
    step(1);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL blink_enter got %b want 1", blink_on); end
    for (int k = 1; k <= 13; k++) begin
      step(1);
      exp = (((k / 4) % 2) == 0);
      n_cmp++; if (blink_on !== exp) begin n_bad++; $display("FAIL blink_run k=%0d got %b want %b", k, blink_on, exp); end
    end
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL blink_restart got %b want 1", blink_on); end
    for (int j = 1; j <= 4; j++) begin
      step(1);
      exp = (j < 4);
      n_cmp++; if (blink_on !== exp) begin n_bad++; $display("FAIL blink_after j=%0d got %b want %b", j, blink_on, exp); end
    end
    set_en = 1'b0;
    step(1);
    n_cmp++; if (blink_on !== 1'b1) begin n_bad++; $display("FAIL blink_commit got %b want 1", blink_on); end
    n_cmp++; if (preset_min !== 8'h10) begin n_bad++; $display("FAIL blink_commit_min got %h want 10", preset_min); end
    step(1);
  endtask

  task automatic test_reset_mid_edit();
    set_en = 1'b1;
    step(1);
    pulse(1'b0, 1'b1, 1'b0);
    n_cmp++; if (preset_min !== 8'h20) begin n_bad++; $display("FAIL rstedit_work got %h want 20", preset_min); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0100) begin n_bad++; $display("FAIL rstedit_val got %h want 0100", {preset_min, preset_sec}); end
    n_cmp++; if (editing !== 1'b0) begin n_bad++; $display("FAIL rstedit_editing got %b want 0", editing); end
    set_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      n_cmp++; if (load_pulse !== 1'b0) begin n_bad++; $display("FAIL rstedit_load_in got %b want 0", load_pulse); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      n_cmp++; if (load_pulse !== 1'b0) begin n_bad++; $display("FAIL rstedit_load_out got %b want 0", load_pulse); end
    end
    n_cmp++; if ({preset_min, preset_sec} !== 16'h0100) begin n_bad++; $display("FAIL rstedit_after got %h want 0100", {preset_min, preset_sec}); end
    n_cmp++; if (preset_zero !== 1'b0) begin n_bad++; $display("FAIL rstedit_zero got %b want 0", preset_zero); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_units_wrap();
    test_idle_pulses();
    test_no_carry();
    test_sel_inc_clr();
    test_blink();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
